// File: rtl/kl10_ebus_pkg.sv
// Shared KL10 EBUS definitions: controller state encoding, diag sub-function
// codes and the 36-bit big-endian EBUS word.
package kl10_ebus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } ebus_state_e;

  localparam logic [4:6] DIAG_FUNC_0 = 3'b000;
  localparam logic [4:6] DIAG_FUNC_1 = 3'b001;
  localparam logic [4:6] DIAG_FUNC_2 = 3'b010;
  localparam logic [4:6] DIAG_FUNC_3 = 3'b011;
  localparam logic [4:6] DIAG_FUNC_4 = 3'b100;
  localparam logic [4:6] DIAG_FUNC_5 = 3'b101;
  localparam logic [4:6] DIAG_FUNC_6 = 3'b110;
  localparam logic [4:6] DIAG_FUNC_7 = 3'b111;

  typedef logic [0:35] ebus_word_t;

endpackage

// File: rtl/ebus_diag_ctl.sv
// KL10 EBUS diagnostic controller: one load (06X) or read (13X) function per
// command, answered by a single response. Optional macro: EBUS_DIAG_PARITY_EN.
module ebus_diag_ctl
  import kl10_ebus_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdRead,
  input  logic [4:6] cmdDiag,
  input  ebus_word_t cmdData,
  output logic [4:6] diag,
  output logic       diagLoadFunc06X,
  output logic       diagReadFunc13X,
  output ebus_word_t ebusOut,
  input  ebus_word_t ebusIn,
  input  logic       drivingEBUS,
  output logic       rspValid,
  input  logic       rspReady,
  output ebus_word_t rspData,
  output logic       rspError
`ifdef EBUS_DIAG_PARITY_EN
  ,
  output logic       rspParErr
`endif
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > STROBE_CYCLES) ? TIMEOUT_CYCLES : STROBE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  ebus_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             read_q, read_d;
  logic [4:6]       diag_q, diag_d;
  ebus_word_t       data_q, data_d;
  ebus_word_t       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      diag_q     <= DIAG_FUNC_0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      diag_q     <= diag_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    read_d          = read_q;
    diag_d          = diag_q;
    data_d          = data_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    cmdReady        = 1'b0;
    diag            = DIAG_FUNC_0;
    diagLoadFunc06X = 1'b0;
    diagReadFunc13X = 1'b0;
    ebusOut         = '0;
    rspValid        = 1'b0;
    rspData         = '0;
    rspError        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          read_d  = cmdRead;
          diag_d  = cmdDiag;
          data_d  = cmdData;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        diag    = diag_q;
        ebusOut = read_q ? '0 : data_q;
        cnt_d   = CNT_ONE;
        state_d = read_q ? ST_READ : ST_LOAD;
      end

      ST_LOAD: begin
        diag            = diag_q;
        diagLoadFunc06X = 1'b1;
        ebusOut         = data_q;
        if (cnt_q == STROBE_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_READ: begin
        diag            = diag_q;
        diagReadFunc13X = 1'b1;
        // A responder on the final cycle still wins over the timeout.
        if (drivingEBUS) begin
          rsp_data_d = ebusIn;
          rsp_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        rspValid = 1'b1;
        rspData  = rsp_data_q;
        rspError = rsp_err_q;
        if (rspReady) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef EBUS_DIAG_PARITY_EN
  // EBUS words carry odd parity; an even count of ones flags an error.
  assign rspParErr = (state_q == ST_RESP) && read_q && !rsp_err_q && !(^rsp_data_q);
`endif

endmodule

// File: tb/tb_ebus_diag_ctl.sv
// Directed self-checking bench for ebus_diag_ctl (default parameters).
`timescale 1ns/1ps
module tb_ebus_diag_ctl;
  import kl10_ebus_pkg::*;

  logic       clk;
  logic       resetN;
  logic       cmdValid;
  logic       cmdReady;
  logic       cmdRead;
  logic [4:6] cmdDiag;
  ebus_word_t cmdData;
  logic [4:6] diag;
  logic       diagLoadFunc06X;
  logic       diagReadFunc13X;
  ebus_word_t ebusOut;
  ebus_word_t ebusIn;
  logic       drivingEBUS;
  logic       rspValid;
  logic       rspReady;
  ebus_word_t rspData;
  logic       rspError;
`ifdef EBUS_DIAG_PARITY_EN
  logic       rspParErr;
`endif

  int total;
  int bad;

  ebus_diag_ctl dut (
    .clk             (clk),
    .resetN          (resetN),
    .cmdValid        (cmdValid),
    .cmdReady        (cmdReady),
    .cmdRead         (cmdRead),
    .cmdDiag         (cmdDiag),
    .cmdData         (cmdData),
    .diag            (diag),
    .diagLoadFunc06X (diagLoadFunc06X),
    .diagReadFunc13X (diagReadFunc13X),
    .ebusOut         (ebusOut),
    .ebusIn          (ebusIn),
    .drivingEBUS     (drivingEBUS),
    .rspValid        (rspValid),
    .rspReady        (rspReady),
    .rspData         (rspData),
    .rspError        (rspError)
`ifdef EBUS_DIAG_PARITY_EN
    ,
    .rspParErr       (rspParErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one accepting edge, then scramble cmd* inputs.
  task automatic issue(input logic rd, input logic [4:6] d, input ebus_word_t w);
    cmdValid = 1'b1;
    cmdRead  = rd;
    cmdDiag  = d;
    cmdData  = w;
    step();
    cmdValid = 1'b0;
    cmdRead  = ~rd;
    cmdDiag  = ~d;
    cmdData  = ~w;
  endtask

  task automatic release_rsp();
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; cmdValid = 1'b0; cmdRead = 1'b0; cmdDiag = 3'b000; cmdData = '0;
    ebusIn = '0; drivingEBUS = 1'b0; rspReady = 1'b0;
    repeat (2) step();
    total++; if ({diag, diagLoadFunc06X, diagReadFunc13X} !== 5'b0) begin bad++; $display("FAIL reset_strobes act=%b exp=00000", {diag, diagLoadFunc06X, diagReadFunc13X}); end
    total++; if (ebusOut !== 36'o0) begin bad++; $display("FAIL reset_ebusOut act=%o exp=0", ebusOut); end
    total++; if ({rspValid, rspError, rspData} !== 38'b0) begin bad++; $display("FAIL reset_rsp act=%b/%b/%o exp=0/0/0", rspValid, rspError, rspData); end
`ifdef EBUS_DIAG_PARITY_EN
    total++; if (rspParErr !== 1'b0) begin bad++; $display("FAIL reset_parerr act=%b exp=0", rspParErr); end
`endif
    #3 resetN = 1'b1;
    step();
    total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL reset_cmdReady act=%b exp=1", cmdReady); end
    $display("txn reset released");
  endtask

  task automatic test_load();
    cmdValid = 1'b1;
    total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL load_idle_ready act=%b exp=1", cmdReady); end
    issue(1'b0, 3'b010, 36'o123456701234);
    total++; if ({diag, diagLoadFunc06X, diagReadFunc13X} !== 5'b01000) begin bad++; $display("FAIL load_setup act=%b exp=01000", {diag, diagLoadFunc06X, diagReadFunc13X}); end
    total++; if (ebusOut !== 36'o123456701234) begin bad++; $display("FAIL load_setup_ebus act=%o exp=123456701234", ebusOut); end
    step();
    for (int i = 1; i <= 2; i++) begin
      total++; if ({diag, diagLoadFunc06X, diagReadFunc13X} !== 5'b01010) begin bad++; $display("FAIL load_strobe%0d act=%b exp=01010", i, {diag, diagLoadFunc06X, diagReadFunc13X}); end
      total++; if (ebusOut !== 36'o123456701234) begin bad++; $display("FAIL load_ebus%0d act=%o exp=123456701234", i, ebusOut); end
      step();
    end
    total++; if ({diag, diagLoadFunc06X, ebusOut} !== 40'b0) begin bad++; $display("FAIL load_resp_quiet act=%b/%b/%o exp=000/0/0", diag, diagLoadFunc06X, ebusOut); end
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o0}) begin bad++; $display("FAIL load_resp act=%b/%b/%o exp=1/0/0", rspValid, rspError, rspData); end
    release_rsp();
    total++; if ({cmdReady, rspValid} !== 2'b10) begin bad++; $display("FAIL load_back_idle act=%b exp=10", {cmdReady, rspValid}); end
    $display("txn load diag=2 data=123456701234 done");
  endtask

  task automatic test_read_ack();
    issue(1'b1, 3'b101, 36'o0);
    total++; if ({diag, diagLoadFunc06X, diagReadFunc13X} !== 5'b10100) begin bad++; $display("FAIL read_setup act=%b exp=10100", {diag, diagLoadFunc06X, diagReadFunc13X}); end
    total++; if (ebusOut !== 36'o0) begin bad++; $display("FAIL read_setup_ebus act=%o exp=0", ebusOut); end
    drivingEBUS = 1'b1; ebusIn = 36'o777777777777;  // must be ignored in SETUP
    step();
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    for (int c = 1; c <= 3; c++) begin
      total++; if ({diag, diagLoadFunc06X, diagReadFunc13X} !== 5'b10101) begin bad++; $display("FAIL read_strobe%0d act=%b exp=10101", c, {diag, diagLoadFunc06X, diagReadFunc13X}); end
      if (c == 3) begin drivingEBUS = 1'b1; ebusIn = 36'o000000000077; end
      step();
    end
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    total++; if (diagReadFunc13X !== 1'b0) begin bad++; $display("FAIL read_strobe_drop act=%b exp=0", diagReadFunc13X); end
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o000000000077}) begin bad++; $display("FAIL read_resp act=%b/%b/%o exp=1/0/000000000077", rspValid, rspError, rspData); end
    release_rsp();
    $display("txn read diag=5 ack on cycle 3 data=%o", 36'o77);
  endtask

  task automatic test_timeout();
    int cnt;
    int guard;
    issue(1'b1, 3'b001, 36'o0);
    step();
    ebusIn = 36'o707070707070;
    cnt = 0; guard = 0;
    while (diagReadFunc13X === 1'b1 && guard < 40) begin
      cnt++; guard++;
      step();
    end
    ebusIn = 36'o0;
    total++; if (cnt !== 15) begin bad++; $display("FAIL timeout_strobe_len act=%0d exp=15", cnt); end
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b1, 36'o0}) begin bad++; $display("FAIL timeout_resp act=%b/%b/%o exp=1/1/0", rspValid, rspError, rspData); end
`ifdef EBUS_DIAG_PARITY_EN
    total++; if (rspParErr !== 1'b0) begin bad++; $display("FAIL timeout_parerr act=%b exp=0", rspParErr); end
`endif
    release_rsp();
    $display("txn read timeout after %0d cycles", cnt);
  endtask

  task automatic test_timeout_edge();
    issue(1'b1, 3'b011, 36'o0);
    step();
    repeat (14) step();
    total++; if (diagReadFunc13X !== 1'b1) begin bad++; $display("FAIL edge_cycle15_strobe act=%b exp=1", diagReadFunc13X); end
    drivingEBUS = 1'b1; ebusIn = 36'o000000000007;
    step();
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o000000000007}) begin bad++; $display("FAIL edge_cycle15_resp act=%b/%b/%o exp=1/0/000000000007", rspValid, rspError, rspData); end
    release_rsp();
    $display("txn read ack on cycle 15 data=%o", 36'o7);
  endtask

  task automatic test_resp_hold();
    issue(1'b1, 3'b100, 36'o0);
    step();
    drivingEBUS = 1'b1; ebusIn = 36'o000000001234;
    step();
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    cmdValid = 1'b1; cmdRead = 1'b0; cmdDiag = 3'b110; cmdData = 36'o55;
    for (int i = 0; i < 5; i++) begin
      total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o000000001234}) begin bad++; $display("FAIL hold_rsp%0d act=%b/%b/%o exp=1/0/000000001234", i, rspValid, rspError, rspData); end
      total++; if (cmdReady !== 1'b0) begin bad++; $display("FAIL hold_cmdReady%0d act=%b exp=0", i, cmdReady); end
      step();
    end
    release_rsp();
    total++; if ({cmdReady, rspValid, diag} !== 5'b10000) begin bad++; $display("FAIL hold_exit_idle act=%b exp=10000", {cmdReady, rspValid, diag}); end
    step();
    cmdValid = 1'b0;
    total++; if ({cmdReady, diag} !== 4'b0110) begin bad++; $display("FAIL hold_next_accept act=%b exp=0110", {cmdReady, diag}); end
    repeat (3) step();
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o0}) begin bad++; $display("FAIL hold_next_resp act=%b/%b/%o exp=1/0/0", rspValid, rspError, rspData); end
    release_rsp();
    $display("txn response held 5 cycles, follow-up load done");
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b111, 36'o765432107654);
    repeat (2) step();
    total++; if (diagLoadFunc06X !== 1'b1) begin bad++; $display("FAIL rst_mid_in_load act=%b exp=1", diagLoadFunc06X); end
    #2 resetN = 1'b0;
    #1;
    total++; if ({diag, diagLoadFunc06X, diagReadFunc13X, ebusOut} !== 41'b0) begin bad++; $display("FAIL rst_mid_async act=%b/%b/%b/%o exp=000/0/0/0", diag, diagLoadFunc06X, diagReadFunc13X, ebusOut); end
    total++; if (rspValid !== 1'b0) begin bad++; $display("FAIL rst_mid_rspValid act=%b exp=0", rspValid); end
    step();
    #3 resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({cmdReady, rspValid} !== 2'b10) begin bad++; $display("FAIL rst_mid_no_rsp%0d act=%b exp=10", i, {cmdReady, rspValid}); end
    end
    issue(1'b1, 3'b010, 36'o0);
    step();
    drivingEBUS = 1'b1; ebusIn = 36'o000000000003;
    step();
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    total++; if ({rspValid, rspError, rspData} !== {1'b1, 1'b0, 36'o000000000003}) begin bad++; $display("FAIL rst_mid_next_read act=%b/%b/%o exp=1/0/000000000003", rspValid, rspError, rspData); end
`ifdef EBUS_DIAG_PARITY_EN
    total++; if (rspParErr !== 1'b1) begin bad++; $display("FAIL parity_even act=%b exp=1", rspParErr); end
`endif
    release_rsp();
    $display("txn reset during load abandoned, next read data=%o", 36'o3);
  endtask

`ifdef EBUS_DIAG_PARITY_EN
  task automatic test_parity();
    issue(1'b1, 3'b000, 36'o0);
    step();
    drivingEBUS = 1'b1; ebusIn = 36'o000000000001;
    step();
    drivingEBUS = 1'b0; ebusIn = 36'o0;
    total++; if ({rspValid, rspParErr} !== 2'b10) begin bad++; $display("FAIL parity_odd act=%b exp=10", {rspValid, rspParErr}); end
    release_rsp();
    $display("txn parity read data=%o", 36'o1);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load();
    test_read_ack();
    test_timeout();
    test_timeout_edge();
    test_resp_hold();
    test_reset_mid();
`ifdef EBUS_DIAG_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
